// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the configurable oversampled UART receiver.
package uart_rx_pkg;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_PARITY = 5'b01000,
        ST_STOP   = 5'b10000
    } rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Tick count one before the middle of a bit; the vote window is M-1..M+1.
    function automatic int mid_tick(input int oversample);
        return oversample / 2 - 1;
    endfunction

    // Mode 2'b11 is reserved and behaves like PAR_NONE.
    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchroniser, falling-edge detect and 3-sample
// majority vote around mid-bit.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    localparam int TW = $clog2(OVERSAMPLE)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          rx_data,
    input  logic          s_ticks,
    input  logic          active,
    input  logic [TW-1:0] tick_cnt,
    output logic          rxs,
    output logic          fall_edge,
    output logic          bit_val,
    output logic          bit_valid
);

    localparam logic [TW-1:0] M_LO  = TW'(mid_tick(OVERSAMPLE) - 1);
    localparam logic [TW-1:0] M_MID = TW'(mid_tick(OVERSAMPLE));
    localparam logic [TW-1:0] M_HI  = TW'(mid_tick(OVERSAMPLE) + 1);

    logic [1:0] sync_q;
    logic       rxs_d;
    logic       smp_a;
    logic       smp_b;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
            rxs_d  <= 1'b1;
            smp_a  <= 1'b1;
            smp_b  <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rx_data};
            rxs_d  <= sync_q[1];
            if (s_ticks && active && tick_cnt == M_LO)
                smp_a <= sync_q[1];
            if (s_ticks && active && tick_cnt == M_MID)
                smp_b <= sync_q[1];
        end
    end

    assign rxs       = sync_q[1];
    assign fall_edge = rxs_d & ~rxs;

    // Third vote is the live line, so the bit resolves on the M+1 tick itself.
    assign bit_valid = s_ticks & active & (tick_cnt == M_HI);
    assign bit_val   = (smp_a & smp_b) | (smp_a & rxs) | (smp_b & rxs);

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with configurable data width, run-time parity
// mode, 1 or 2 stop bits, and parity/framing/break reporting.
module uart_rx_cfg
    import uart_rx_pkg::*;
#(
    parameter int N_BITS_DATA = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int N_BITS_STOP = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   s_ticks,
    input  logic                   rx_data,
    input  logic [1:0]             parity_mode,
    output logic                   rx_done_tick,
    output logic [N_BITS_DATA-1:0] data_o,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   break_o,
    output logic                   busy
);

    localparam int              TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]   TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]      DATA_LAST = 4'(N_BITS_DATA - 1);
    localparam logic [3:0]      STOP_LAST = 4'(N_BITS_STOP - 1);

    rx_state_e              state_q, state_d;
    logic [TW-1:0]          tick_q;
    logic [3:0]             bit_q;
    logic [N_BITS_DATA-1:0] shift_q;
    logic [1:0]             par_mode_q;
    logic                   par_bit_q;
    logic                   stop0_q;
    logic                   ferr_pend_q;
    logic                   fall_pend_q;

    logic rxs, fall_edge, bit_val, bit_valid;
    logic active, bit_end, final_mid;
    logic stop0_now, perr_now, brk_now;

    uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
        .clock     (clock),
        .reset     (reset),
        .rx_data   (rx_data),
        .s_ticks   (s_ticks),
        .active    (active),
        .tick_cnt  (tick_q),
        .rxs       (rxs),
        .fall_edge (fall_edge),
        .bit_val   (bit_val),
        .bit_valid (bit_valid)
    );

    assign active    = (state_q != ST_IDLE);
    assign busy      = active;
    assign bit_end   = s_ticks & active & (tick_q == TICK_LAST);
    assign final_mid = bit_valid & (state_q == ST_STOP) & (bit_q == STOP_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            // A pending edge caught during the last stop mid-bit still counts
            // if the line is still low, so back-to-back frames are not lost.
            ST_IDLE:   if (fall_edge || (fall_pend_q && !rxs)) state_d = ST_START;
            ST_START:  if (bit_valid && bit_val)                state_d = ST_IDLE;
                       else if (bit_end)                        state_d = ST_DATA;
            ST_DATA:   if (bit_end && bit_q == DATA_LAST)
                           state_d = par_enabled(par_mode_q) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end)                             state_d = ST_STOP;
            ST_STOP:   if (final_mid)                           state_d = ST_IDLE;
            default:                                            state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            tick_q <= '0;
        else if (!active)
            tick_q <= '0;
        else if (s_ticks)
            tick_q <= (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_q       <= '0;
            shift_q     <= '0;
            par_mode_q  <= PAR_NONE;
            par_bit_q   <= 1'b0;
            stop0_q     <= 1'b0;
            ferr_pend_q <= 1'b0;
            fall_pend_q <= 1'b0;
        end else begin
            fall_pend_q <= final_mid & fall_edge;
            case (state_q)
                ST_IDLE: begin
                    bit_q       <= '0;
                    ferr_pend_q <= 1'b0;
                end
                ST_START: begin
                    if (bit_valid && !bit_val)
                        par_mode_q <= parity_mode;
                end
                ST_DATA: begin
                    if (bit_valid)
                        shift_q <= {bit_val, shift_q[N_BITS_DATA-1:1]};
                    if (bit_end)
                        bit_q <= (bit_q == DATA_LAST) ? '0 : bit_q + 4'd1;
                end
                ST_PARITY: begin
                    if (bit_valid)
                        par_bit_q <= bit_val;
                end
                ST_STOP: begin
                    if (bit_valid) begin
                        if (!bit_val)
                            ferr_pend_q <= 1'b1;
                        if (bit_q == '0)
                            stop0_q <= bit_val;
                    end
                    if (bit_end)
                        bit_q <= bit_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // With one stop bit the first stop sample is the one resolving right now.
    assign stop0_now = (bit_q == '0) ? bit_val : stop0_q;
    assign perr_now  = par_enabled(par_mode_q) &
                       ((^shift_q ^ par_bit_q) != (par_mode_q == PAR_ODD));
    assign brk_now   = ~|shift_q & ~(par_enabled(par_mode_q) & par_bit_q) & ~stop0_now;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_done_tick <= 1'b0;
            data_o       <= '0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            break_o      <= 1'b0;
        end else begin
            rx_done_tick <= final_mid;
            if (final_mid) begin
                data_o     <= shift_q;
                parity_err <= perr_now;
                frame_err  <= ferr_pend_q | ~bit_val;
                break_o    <= brk_now;
            end
        end
    end

endmodule
